// File: rtl/upi_payment_ctrl.sv
// UPI payment controller: latches an amount, runs timed bank attempts with retry
// and cancel, and closes every transaction with a one-cycle pay_done and result.
module upi_payment_ctrl #(
  parameter int AMOUNT_W    = 8,
  parameter int MIN_LATENCY = 4,
  parameter int TIMEOUT     = 16,
  parameter int MAX_RETRY   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pay_req,
  input  logic [AMOUNT_W-1:0] pay_amount,
  input  logic                pay_cancel,
  output logic                bank_req,
  input  logic                bank_resp_valid,
  input  logic                bank_resp_ok,
  output logic                pay_done,
  output logic                upi_busy,
  output logic                upi_success,
  output logic                upi_fail,
  output logic [2:0]          fail_code,
  output logic [2:0]          retry_cnt,
  output logic [AMOUNT_W-1:0] txn_amount
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] MIN_LAT    = TW'(MIN_LATENCY);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]    RETRY_MAX  = 3'(MAX_RETRY);

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_DECLINED  = 3'd1;
  localparam logic [2:0] FC_TIMEOUT   = 3'd2;
  localparam logic [2:0] FC_CANCELLED = 3'd3;
  localparam logic [2:0] FC_ZERO_AMT  = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PROCESS = 3'd1,
    RETRY   = 3'd2,
    SUCCESS = 3'd3,
    FAIL    = 3'd4
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [TW-1:0]         timer_r, timer_nxt_s;
  logic [2:0]            fail_code_nxt_s;
  logic [2:0]            retry_nxt_s;
  logic [AMOUNT_W-1:0]   amount_nxt_s;
  logic                  resp_accept_s;

  // Next-state and next-value decode for the transaction bookkeeping.
  always_comb begin
    state_nxt_s     = state_r;
    fail_code_nxt_s = fail_code;
    retry_nxt_s     = retry_cnt;
    amount_nxt_s    = txn_amount;
    resp_accept_s   = bank_resp_valid && (timer_r >= MIN_LAT);
    case (state_r)
      IDLE: begin
        if (pay_req) begin
          if (pay_amount != {AMOUNT_W{1'b0}}) begin
            amount_nxt_s    = pay_amount;
            retry_nxt_s     = 3'd0;
            fail_code_nxt_s = FC_NONE;
            state_nxt_s     = PROCESS;
          end else begin
            fail_code_nxt_s = FC_ZERO_AMT;
            state_nxt_s     = FAIL;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PROCESS: begin
        // A settled bank response outranks a cancel or a timeout in the same cycle.
        if (resp_accept_s && bank_resp_ok) begin
          state_nxt_s = SUCCESS;
        end else if (resp_accept_s) begin
          fail_code_nxt_s = FC_DECLINED;
          state_nxt_s     = FAIL;
        end else if (pay_cancel) begin
          fail_code_nxt_s = FC_CANCELLED;
          state_nxt_s     = FAIL;
        end else if (timer_r == TIMER_LAST) begin
          if (retry_cnt < RETRY_MAX) begin
            state_nxt_s = RETRY;
          end else begin
            fail_code_nxt_s = FC_TIMEOUT;
            state_nxt_s     = FAIL;
          end
        end else begin
          state_nxt_s = PROCESS;
        end
      end
      RETRY: begin
        if (pay_cancel) begin
          fail_code_nxt_s = FC_CANCELLED;
          state_nxt_s     = FAIL;
        end else begin
          retry_nxt_s = retry_cnt + 3'd1;
          state_nxt_s = PROCESS;
        end
      end
      SUCCESS: state_nxt_s = IDLE;
      FAIL:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase

    if ((state_r == PROCESS) && (state_nxt_s == PROCESS)) begin
      timer_nxt_s = timer_r + TW'(1);
    end else begin
      timer_nxt_s = {TW{1'b0}};
    end
  end

  // State, timer, bookkeeping and outputs; outputs are registered from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      timer_r     <= {TW{1'b0}};
      fail_code   <= FC_NONE;
      retry_cnt   <= 3'd0;
      txn_amount  <= {AMOUNT_W{1'b0}};
      bank_req    <= 1'b0;
      pay_done    <= 1'b0;
      upi_busy    <= 1'b0;
      upi_success <= 1'b0;
      upi_fail    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      timer_r     <= timer_nxt_s;
      fail_code   <= fail_code_nxt_s;
      retry_cnt   <= retry_nxt_s;
      txn_amount  <= amount_nxt_s;
      bank_req    <= (state_nxt_s == PROCESS) && (timer_nxt_s == {TW{1'b0}});
      pay_done    <= (state_nxt_s == SUCCESS) || (state_nxt_s == FAIL);
      upi_busy    <= (state_nxt_s == PROCESS) || (state_nxt_s == RETRY);
      upi_success <= (state_nxt_s == SUCCESS);
      upi_fail    <= (state_nxt_s == FAIL);
    end
  end

endmodule

// File: tb/tb_upi_payment_ctrl.sv
// Scoreboard bench for upi_payment_ctrl: stimulus pushes expected results,
// a monitor pops and compares them on every pay_done.
module tb_upi_payment_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pay_req;
  logic [7:0] pay_amount;
  logic       pay_cancel;
  logic       bank_req;
  logic       bank_resp_valid;
  logic       bank_resp_ok;
  logic       pay_done;
  logic       upi_busy;
  logic       upi_success;
  logic       upi_fail;
  logic [2:0] fail_code;
  logic [2:0] retry_cnt;
  logic [7:0] txn_amount;

  upi_payment_ctrl #(.AMOUNT_W(8), .MIN_LATENCY(4), .TIMEOUT(16), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst), .pay_req(pay_req), .pay_amount(pay_amount),
    .pay_cancel(pay_cancel), .bank_req(bank_req), .bank_resp_valid(bank_resp_valid),
    .bank_resp_ok(bank_resp_ok), .pay_done(pay_done), .upi_busy(upi_busy),
    .upi_success(upi_success), .upi_fail(upi_fail), .fail_code(fail_code),
    .retry_cnt(retry_cnt), .txn_amount(txn_amount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int succ;
    int code;
    int retry;
    int amt;
    int banks;
    int done_cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   base   = 0;
  int   checks = 0;
  int   errors = 0;
  int   bank_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: count bank requests and score each completed transaction.
  always @(negedge clk) begin
    if (rst) begin
      bank_cnt = 0;
    end else begin
      if (bank_req) bank_cnt++;
      if (pay_done) begin
        if (q.size() == 0) begin
          check("unexpected_pay_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("upi_success", int'(upi_success), e.succ);
          check("upi_fail", int'(upi_fail), 1 - e.succ);
          check("fail_code", int'(fail_code), e.code);
          check("retry_cnt", int'(retry_cnt), e.retry);
          check("txn_amount", int'(txn_amount), e.amt);
          check("bank_req_count", bank_cnt, e.banks);
        end
        bank_cnt = 0;
      end
    end
  end

  task automatic issue(input int amt, input bit push, input int succ, input int code,
                       input int retry, input int eamt, input int banks, input int done_rel);
    exp_t e;
    @(negedge clk);
    base = cyc;
    if (push) begin
      e.succ = succ; e.code = code; e.retry = retry; e.amt = eamt;
      e.banks = banks; e.done_cyc = base + done_rel;
      q.push_back(e);
    end
    pay_req    = 1'b1;
    pay_amount = amt[7:0];
    @(negedge clk);
    pay_req = 1'b0;
  endtask

  task automatic goto_rel(input int r);
    int n = 0;
    while (cyc < base + r && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic resp(input int r, input logic ok, input logic cancel);
    goto_rel(r);
    bank_resp_valid = 1'b1;
    bank_resp_ok    = ok;
    pay_cancel      = cancel;
    @(negedge clk);
    bank_resp_valid = 1'b0;
    bank_resp_ok    = 1'b0;
    pay_cancel      = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; pay_req = 1'b0; pay_amount = 8'd0; pay_cancel = 1'b0;
    bank_resp_valid = 1'b0; bank_resp_ok = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pay_done", int'(pay_done), 0);
    check("reset_busy", int'(upi_busy), 0);
    check("reset_bank_req", int'(bank_req), 0);
    check("reset_fail_code", int'(fail_code), 0);
    check("reset_txn_amount", int'(txn_amount), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal approval at timer=4.
    issue(25, 1'b1, 1, 0, 0, 25, 1, 6);
    check("t1_bank_req_c1", int'(bank_req), 1);
    check("t1_busy_c1", int'(upi_busy), 1);
    goto_rel(2);
    check("t1_bank_req_c2", int'(bank_req), 0);
    resp(5, 1'b1, 1'b0);
    check("t1_busy_c6", int'(upi_busy), 0);
    drain();

    // Early response ignored, then full timeout with two retries.
    issue(40, 1'b1, 0, 2, 2, 40, 3, 51);
    resp(3, 1'b1, 1'b0);
    goto_rel(17);
    check("t2_busy_in_retry", int'(upi_busy), 1);
    drain();

    // Second attempt declined at timer=6.
    issue(60, 1'b1, 0, 1, 1, 60, 2, 25);
    resp(24, 1'b0, 1'b0);
    drain();

    // Response and cancel together: response wins.
    issue(70, 1'b1, 1, 0, 0, 70, 1, 7);
    resp(6, 1'b1, 1'b1);
    drain();

    // Cancel alone at timer=3.
    issue(80, 1'b1, 0, 3, 0, 80, 1, 5);
    goto_rel(4);
    pay_cancel = 1'b1;
    @(negedge clk);
    pay_cancel = 1'b0;
    drain();

    // Zero amount fails immediately; txn_amount keeps the previous value.
    issue(0, 1'b1, 0, 4, 0, 80, 0, 1);
    drain();

    // pay_req during PROCESS is ignored.
    issue(90, 1'b1, 1, 0, 0, 90, 1, 9);
    goto_rel(3);
    pay_req = 1'b1; pay_amount = 8'd200;
    @(negedge clk);
    pay_req = 1'b0;
    goto_rel(5);
    check("t5_amount_held", int'(txn_amount), 90);
    resp(8, 1'b1, 1'b0);
    drain();

    // Reset mid-attempt at timer=7: no pay_done, everything cleared.
    issue(100, 1'b0, 0, 0, 0, 0, 0, 0);
    goto_rel(8);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_pay_done", int'(pay_done), 0);
    check("t6_rst_busy", int'(upi_busy), 0);
    check("t6_rst_bank_req", int'(bank_req), 0);
    check("t6_rst_fail", int'(upi_fail), 0);
    check("t6_rst_txn_amount", int'(txn_amount), 0);
    check("t6_rst_retry", int'(retry_cnt), 0);
    rst = 1'b0;
    @(negedge clk);
    issue(33, 1'b1, 1, 0, 0, 33, 1, 6);
    resp(5, 1'b1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
